// File: rtl/hazard_ctrl.sv
// Load-use hazard detection plus a full-stall FSM for memory waits and control redirects.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.

module hazard_src_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              vld,
  input  logic [REG_AW-1:0] dst,
  output logic              hit
);
  assign hit = vld && (src == dst);
endmodule

module hazard_ctrl #(
  parameter int NUM_SRC      = 2,
  parameter int REG_AW       = 5,
  parameter int REDIRECT_CYC = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memread_id_ex,
  input  logic                      memread_ex_mem,
  input  logic                      memwrite_ex_mem,
  input  logic                      mem_ready,
  input  logic                      interrupt,
  input  logic                      branch,
  input  logic                      rti,
  input  logic [NUM_SRC*REG_AW-1:0] src_regs_if_id,
  input  logic [NUM_SRC-1:0]        src_valid_if_id,
  input  logic [REG_AW-1:0]         dst_reg_id_ex,
  output logic                      hazard,
  output logic                      stall_mem,
  output logic                      mem_timeout,
  output logic [15:0]               perf_load_stalls,
  output logic [15:0]               perf_pipe_stalls
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, REDIRECT} state_t;

  localparam logic [3:0] RCNT_INIT = 4'(REDIRECT_CYC - 1);
  localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);
  localparam logic       TMO_FIRST = (MEM_TIMEOUT == 1);

  state_t       state;
  logic [3:0]   rcnt;
  logic [7:0]   wait_cnt;
  logic         redirect_pending;
  logic [NUM_SRC-1:0] src_hit;

  wire mem_req = memread_ex_mem | memwrite_ex_mem;
  wire redir   = interrupt | branch | rti;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_cmp #(.REG_AW(REG_AW)) u_cmp (
      .src (src_regs_if_id[g*REG_AW +: REG_AW]),
      .vld (src_valid_if_id[g]),
      .dst (dst_reg_id_ex),
      .hit (src_hit[g])
    );
  end

  assign hazard    = memread_id_ex && (dst_reg_id_ex != '0) && (|src_hit);
  assign stall_mem = (state != IDLE) || (mem_req || redir);

  // wait_cnt is the 1-based index of the current MEM_WAIT cycle; mem_timeout is
  // raised ahead of time so it is high during the final (forced-release) cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      rcnt             <= '0;
      wait_cnt         <= '0;
      redirect_pending <= 1'b0;
      mem_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state            <= MEM_WAIT;
            wait_cnt         <= 8'd1;
            mem_timeout      <= TMO_FIRST;
            redirect_pending <= redir;
          end else if (redir) begin
            state <= REDIRECT;
            rcnt  <= RCNT_INIT;
          end
        end
        MEM_WAIT: begin
          if (redir) redirect_pending <= 1'b1;
          if (mem_timeout || mem_ready) begin
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
            if (redirect_pending || redir) begin
              state            <= REDIRECT;
              rcnt             <= RCNT_INIT;
              redirect_pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
            mem_timeout <= ((wait_cnt + 8'd1) == TMO);
          end
        end
        REDIRECT: begin
          if (redir) begin
            rcnt <= RCNT_INIT;
          end else if (rcnt == '0) begin
            if (mem_req) begin
              state       <= MEM_WAIT;
              wait_cnt    <= 8'd1;
              mem_timeout <= TMO_FIRST;
            end else begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] load_cnt, pipe_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= '0;
      pipe_cnt <= '0;
    end else begin
      if (hazard && (load_cnt != 16'hFFFF))    load_cnt <= load_cnt + 16'd1;
      if (stall_mem && (pipe_cnt != 16'hFFFF)) pipe_cnt <= pipe_cnt + 16'd1;
    end
  end

  assign perf_load_stalls = load_cnt;
  assign perf_pipe_stalls = pipe_cnt;
`else
  assign perf_load_stalls = '0;
  assign perf_pipe_stalls = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected {hazard,stall_mem,mem_timeout}
// per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;
  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] MR   = 6'b100000;
  localparam logic [5:0] MW   = 6'b010000;
  localparam logic [5:0] RDY  = 6'b001000;
  localparam logic [5:0] IRQ  = 6'b000100;
  localparam logic [5:0] BR   = 6'b000010;
  localparam logic [5:0] RTI  = 6'b000001;

  logic clk = 1'b0;
  logic rst_n;
  logic memread_id_ex, memread_ex_mem, memwrite_ex_mem, mem_ready;
  logic interrupt, branch, rti;
  logic [NUM_SRC*REG_AW-1:0] src_regs_if_id;
  logic [NUM_SRC-1:0]        src_valid_if_id;
  logic [REG_AW-1:0]         dst_reg_id_ex;
  logic hazard, stall_mem, mem_timeout;
  logic [15:0] perf_load_stalls, perf_pipe_stalls;

  hazard_ctrl #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .REDIRECT_CYC(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread_id_ex(memread_id_ex), .memread_ex_mem(memread_ex_mem),
    .memwrite_ex_mem(memwrite_ex_mem), .mem_ready(mem_ready),
    .interrupt(interrupt), .branch(branch), .rti(rti),
    .src_regs_if_id(src_regs_if_id), .src_valid_if_id(src_valid_if_id),
    .dst_reg_id_ex(dst_reg_id_ex),
    .hazard(hazard), .stall_mem(stall_mem), .mem_timeout(mem_timeout),
    .perf_load_stalls(perf_load_stalls), .perf_pipe_stalls(perf_pipe_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if ({hazard, stall_mem, mem_timeout} !== e.exp) begin
        n_err++;
        $display("FAIL %s: got {hazard,stall,tmo}=%b want %b", e.name, {hazard, stall_mem, mem_timeout}, e.exp);
      end
    end
  end

  task automatic step(input string nm, input logic [5:0] c, input logic [2:0] e);
    {memread_ex_mem, memwrite_ex_mem, mem_ready, interrupt, branch, rti} = c;
    exp_q.push_back('{nm, e});
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic set_hz(input logic mr, input logic [REG_AW-1:0] dst,
                        input logic [REG_AW-1:0] s1, input logic [REG_AW-1:0] s0,
                        input logic [1:0] v);
    memread_id_ex   = mr;
    dst_reg_id_ex   = dst;
    src_regs_if_id  = {s1, s0};
    src_valid_if_id = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {memread_ex_mem, memwrite_ex_mem, mem_ready, interrupt, branch, rti} = NONE;
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    step("reset_state", NONE, 3'b000);
    chk("reset_perf_load", perf_load_stalls, 16'h0);
    chk("reset_perf_pipe", perf_pipe_stalls, 16'h0);
    rst_n = 1'b1;

    // load-use detection
    set_hz(1'b1, 5'd5, 5'd0, 5'd5, 2'b01); step("hz_src0_match", NONE, 3'b100);
    set_hz(1'b1, 5'd0, 5'd0, 5'd0, 2'b01); step("hz_dst_zero",   NONE, 3'b000);
    set_hz(1'b1, 5'd5, 5'd5, 5'd3, 2'b01); step("hz_src1_inval", NONE, 3'b000);
    set_hz(1'b1, 5'd5, 5'd5, 5'd3, 2'b11); step("hz_src1_valid", NONE, 3'b100);
    set_hz(1'b0, 5'd5, 5'd5, 5'd5, 2'b11); step("hz_no_load",    NONE, 3'b000);
    set_hz(1'b1, 5'd7, 5'd7, 5'd0, 2'b10); step("hz_with_stall", MR,   3'b110);
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    step("hz_ws_wait", RDY, 3'b010);
    step("hz_ws_idle", NONE, 3'b000);

    // load, mem_ready three cycles later
    step("ld_req", MR, 3'b010);
    step("ld_w1", NONE, 3'b010);
    step("ld_w2", NONE, 3'b010);
    step("ld_rdy", RDY, 3'b010);
    step("ld_idle", NONE, 3'b000);
    step("ld_idle2", NONE, 3'b000);

    // store + branch together, then redirect
    step("stbr_req", MW | BR, 3'b010);
    step("stbr_w1", NONE, 3'b010);
    step("stbr_rdy", RDY, 3'b010);
    step("stbr_r1", NONE, 3'b010);
    step("stbr_r0", NONE, 3'b010);
    step("stbr_idle", NONE, 3'b000);

    // timeout after 4 MEM_WAIT cycles
    step("tmo_req", MR, 3'b010);
    step("tmo_w1", NONE, 3'b010);
    step("tmo_w2", NONE, 3'b010);
    step("tmo_w3", NONE, 3'b010);
    step("tmo_w4", NONE, 3'b011);
    step("tmo_idle", NONE, 3'b000);

    // redirect arriving during MEM_WAIT is held pending
    step("pend_req", MR, 3'b010);
    step("pend_irq", IRQ, 3'b010);
    step("pend_rdy", RDY, 3'b010);
    step("pend_r1", NONE, 3'b010);
    step("pend_r0", NONE, 3'b010);
    step("pend_idle", NONE, 3'b000);

    // redirect reload while in REDIRECT
    step("rel_br", BR, 3'b010);
    step("rel_rti", RTI, 3'b010);
    step("rel_r1", NONE, 3'b010);
    step("rel_r0", NONE, 3'b010);
    step("rel_idle", NONE, 3'b000);

    // REDIRECT expiring into MEM_WAIT
    step("r2m_irq", IRQ, 3'b010);
    step("r2m_r1", NONE, 3'b010);
    step("r2m_r0_mr", MR, 3'b010);
    step("r2m_rdy", RDY, 3'b010);
    step("r2m_idle", NONE, 3'b000);

    // mem_ready coincident with the request is ignored
    step("ign_req_rdy", MR | RDY, 3'b010);
    step("ign_w1", NONE, 3'b010);
    step("ign_rdy", RDY, 3'b010);
    step("ign_idle", NONE, 3'b000);

    // reset while in REDIRECT
    step("rst_br", BR, 3'b010);
    rst_n = 1'b0;
    step("rst_in_redir", NONE, 3'b010);
    rst_n = 1'b1;
    step("rst_after", NONE, 3'b000);
    chk("rst_perf_load", perf_load_stalls, 16'h0);
    chk("rst_perf_pipe", perf_pipe_stalls, 16'h0);

    // long hazard hold: saturating counter when enabled
    set_hz(1'b1, 5'd5, 5'd0, 5'd5, 2'b01);
    repeat (70000) @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    chk("perf_load_sat", perf_load_stalls, 16'hFFFF);
`else
    chk("perf_load_off", perf_load_stalls, 16'h0);
`endif
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
- REQ-001: Parameter NUM_SRC, default 2: number of decode-stage source register operands checked.
- REQ-002: Parameter REG_AW, default 5: register index width.
- REQ-003: Parameter REDIRECT_CYC, default 2: stall cycles held after a branch, interrupt or rti (range 1..15).
- REQ-004: Parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before forced release (range 1..255).
- REQ-005: Ports, one per line, SHALL be:
  - clk  in  1  sole clock, rising edge
  - rst_n  in  1  synchronous active-low reset
  - memread_id_ex  in  1  load in ID/EX
  - memread_ex_mem  in  1  load in EX/MEM
  - memwrite_ex_mem  in  1  store in EX/MEM
  - mem_ready  in  1  memory access complete (single-cycle pulse)
  - interrupt  in  1  interrupt taken
  - branch  in  1  branch taken
  - rti  in  1  return from interrupt
  - src_regs_if_id  in  NUM_SRC*REG_AW  packed source indices, operand 0 in LSBs
  - src_valid_if_id  in  NUM_SRC  per-operand valid
  - dst_reg_id_ex  in  REG_AW  ID/EX destination index
  - hazard  out  1  load-use: stall IF/ID, insert nop
  - stall_mem  out  1  full pipeline stall
  - mem_timeout  out  1  one-cycle pulse on forced MEM_WAIT release
  - perf_load_stalls  out  16  load-use stall count
  - perf_pipe_stalls  out  16  full-stall count

Function
- REQ-006: hazard SHALL be combinational: memread_id_ex AND dst_reg_id_ex != 0 AND any operand i with src_valid_if_id[i] and index equal to dst_reg_id_ex.
- REQ-007: FSM states SHALL be IDLE, MEM_WAIT, REDIRECT.
- REQ-008: IDLE: memread_ex_mem or memwrite_ex_mem -> MEM_WAIT; else interrupt, branch or rti -> REDIRECT, counter loaded with REDIRECT_CYC-1; else stay.
- REQ-009: Memory request and redirect in the same IDLE cycle -> MEM_WAIT with redirect_pending flag set.
- REQ-010: Redirect event arriving during MEM_WAIT SHALL set redirect_pending; redirect events during REDIRECT SHALL reload the counter with REDIRECT_CYC-1.
- REQ-011: MEM_WAIT exit on mem_ready or when wait counter reaches MEM_TIMEOUT: to REDIRECT if redirect_pending (pending cleared, counter loaded), else to IDLE.
- REQ-012: mem_ready in the IDLE cycle that raises the request SHALL be ignored; MEM_WAIT is entered regardless.
- REQ-013: Timeout exit SHALL pulse mem_timeout for exactly one cycle; mem_ready exit SHALL not.
- REQ-014: REDIRECT SHALL decrement each cycle; at 0 -> IDLE, or -> MEM_WAIT if a memory request is present that cycle.
- REQ-015: stall_mem SHALL equal (state != IDLE) OR (IDLE AND any of memread_ex_mem, memwrite_ex_mem, interrupt, branch, rti).
- REQ-016: Zero-cycle-latency behaviour: stall_mem SHALL assert in the same cycle as the triggering input.
- REQ-017: hazard SHALL be evaluated independently of stall_mem; stall_mem has priority at the pipeline.

Reset
- REQ-018: With rst_n low at a clk rising edge: state IDLE, counters 0, redirect_pending 0, mem_timeout 0, perf counters 0.
- REQ-019: Reset mid-MEM_WAIT or mid-REDIRECT SHALL abandon the operation; stall_mem then follows REQ-015 from IDLE.

Configuration
- REQ-020: Macro HAZARD_PERF_EN defined: perf_load_stalls increments each cycle hazard=1; perf_pipe_stalls increments each cycle stall_mem=1; both saturate at 16'hFFFF.
- REQ-021: HAZARD_PERF_EN undefined: both perf outputs constant 0; no counter flops present.

Verification
- REQ-022: memread_id_ex=1, dst=5, src0=5 valid -> hazard=1; dst=0, src0=0 valid -> hazard=0; src1=5 with src_valid_if_id[1]=0 -> hazard=0.
- REQ-023: memread_ex_mem one cycle, mem_ready 3 cycles later -> stall_mem high 4 cycles, then low; mem_timeout stays 0.
- REQ-024: memwrite_ex_mem plus branch in the same cycle, mem_ready after 2 cycles -> stall_mem high 3 + REDIRECT_CYC (=2) cycles contiguous.
- REQ-025: memread_ex_mem, no mem_ready, MEM_TIMEOUT=4 -> mem_timeout pulses once on the 4th MEM_WAIT cycle; FSM returns to IDLE.
- REQ-026: rst_n low during REDIRECT -> next cycle stall_mem=0 with all inputs low; perf counters 0.
- REQ-027: HAZARD_PERF_EN defined, hazard held 70000 cycles -> perf_load_stalls = 16'hFFFF; undefined -> 0.
